// File: rtl/ifid_stage_pkg.sv
// Shared definitions for the IF/ID stage: next-PC codes, FSM states, reset PC and nop.
// Used by ifid_stage and ifid_stall_mon; optional perf counters are controlled by IFID_PERF_CNT_EN.
package ifid_stage_pkg;

  localparam logic [31:0] PC_RESET    = 32'h0000_3000;
  localparam int          STALL_LIMIT = 15;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;

  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JUMP   = 2'd2;
  localparam logic [1:0] NPC_JR     = 2'd3;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    FLUSH = 2'd3
  } ifid_state_e;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } ifid_reg_t;

  // Fetch addresses are word aligned; low two bits are never honoured.
  function automatic logic [31:0] pc_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifid_stall_mon.sv
// Consecutive-stall watchdog with sticky StallErr; optional total stall/flush counters
// are built only when IFID_PERF_CNT_EN is defined.
module ifid_stall_mon
  import ifid_stage_pkg::*;
#(
  parameter int STALL_LIMIT = ifid_stage_pkg::STALL_LIMIT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
`ifdef IFID_PERF_CNT_EN
  input  logic        i_flush_acc,
  output logic [31:0] o_StallCnt,
  output logic [31:0] o_FlushCnt,
`endif
  output logic        o_StallErr
);

  localparam int unsigned LIM = STALL_LIMIT;

  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       r_err;
  logic       w_hit;

  always_comb begin
    w_cnt_nxt = 4'd0;
    if (i_stall)
      w_cnt_nxt = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
  end

  assign w_hit = i_stall && (32'(w_cnt_nxt) == LIM);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= 4'd0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_err <= r_err | w_hit;
    end
  end

  assign o_StallErr = r_err;

`ifdef IFID_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 32'(i_stall);
      r_flush_cnt <= r_flush_cnt + 32'(i_flush_acc);
    end
  end

  assign o_StallCnt = r_stall_cnt;
  assign o_FlushCnt = r_flush_cnt;
`endif

endmodule

// File: rtl/ifid_stage.sv
// Fetch PC register and IF/ID pipeline register with stall/flush handling.
// Define IFID_PERF_CNT_EN to add o_StallCnt/o_FlushCnt performance counter outputs.
module ifid_stage
  import ifid_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET    = ifid_stage_pkg::PC_RESET,
  parameter int          STALL_LIMIT = ifid_stage_pkg::STALL_LIMIT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_IFIDWr,
  input  logic        i_IFlush,
  input  logic [1:0]  i_NPCOp,
  input  logic [31:0] i_NPC,
  input  logic [31:0] i_Instr,
  output logic [31:0] o_PC,
  output logic [31:0] o_IFID_PC4,
  output logic [31:0] o_IFID_Instr,
  output logic        o_IFID_Valid,
`ifdef IFID_PERF_CNT_EN
  output logic [31:0] o_StallCnt,
  output logic [31:0] o_FlushCnt,
`endif
  output logic        o_StallErr
);

  ifid_state_e r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt, w_pc4;
  ifid_reg_t   r_ifid, w_ifid_nxt;
  logic        w_stall;
  logic        w_flush_acc;

  // Redirect needs only IFlush; NPCOp and NPC[1:0] carry no extra information here.
  logic w_unused;
  assign w_unused = ^{i_NPCOp, i_NPC[1:0]};

  assign w_pc4 = r_pc + 32'd4;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ifid_nxt  = r_ifid;
    case (r_state)
      BOOT: begin
        w_pc_nxt    = w_pc4;
        w_ifid_nxt  = '{pc4: w_pc4, instr: i_Instr, valid: 1'b1};
        w_state_nxt = RUN;
      end
      default: begin
        if (!i_IFIDWr) begin
          w_state_nxt = STALL;
        end else if (i_IFlush) begin
          w_pc_nxt    = pc_align(i_NPC);
          w_ifid_nxt  = '{pc4: w_pc4, instr: NOP_INSTR, valid: 1'b0};
          w_state_nxt = FLUSH;
        end else begin
          w_pc_nxt    = w_pc4;
          w_ifid_nxt  = '{pc4: w_pc4, instr: i_Instr, valid: 1'b1};
          w_state_nxt = RUN;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= BOOT;
      r_pc    <= pc_align(PC_RESET);
      r_ifid  <= '{pc4: 32'd0, instr: NOP_INSTR, valid: 1'b0};
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ifid  <= w_ifid_nxt;
    end
  end

  assign o_PC         = r_pc;
  assign o_IFID_PC4   = r_ifid.pc4;
  assign o_IFID_Instr = r_ifid.instr;
  assign o_IFID_Valid = r_ifid.valid;

  // The boot load is unconditional, so it is neither a stall nor a flush.
  assign w_stall     = !i_IFIDWr && (r_state != BOOT);
  assign w_flush_acc = i_IFIDWr && i_IFlush && (r_state != BOOT);

  ifid_stall_mon #(
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall_mon (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_stall     (w_stall),
`ifdef IFID_PERF_CNT_EN
    .i_flush_acc (w_flush_acc),
    .o_StallCnt  (o_StallCnt),
    .o_FlushCnt  (o_FlushCnt),
`endif
    .o_StallErr  (o_StallErr)
  );

`ifndef IFID_PERF_CNT_EN
  logic w_unused_flush;
  assign w_unused_flush = w_flush_acc;
`endif

endmodule

// File: tb/tb_ifid_stage.sv
// Directed self-checking bench for ifid_stage: boot, run, stall, flush, watchdog, wrap, async reset.
// Perf counter checks are compiled in when IFID_PERF_CNT_EN is defined.
module tb_ifid_stage;
  import ifid_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic        ifid_wr;
  logic        iflush;
  logic [1:0]  npc_op;
  logic [31:0] npc;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        stall_err;
`ifdef IFID_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  ifid_stage dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_IFIDWr     (ifid_wr),
    .i_IFlush     (iflush),
    .i_NPCOp      (npc_op),
    .i_NPC        (npc),
    .i_Instr      (instr),
    .o_PC         (pc),
    .o_IFID_PC4   (ifid_pc4),
    .o_IFID_Instr (ifid_instr),
    .o_IFID_Valid (ifid_valid),
`ifdef IFID_PERF_CNT_EN
    .o_StallCnt   (stall_cnt),
    .o_FlushCnt   (flush_cnt),
`endif
    .o_StallErr   (stall_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves reset released mid-cycle; the next rising edge is the boot cycle.
  task automatic do_reset();
    rst = 1'b1; ifid_wr = 1'b1; iflush = 1'b0; npc_op = NPC_PLUS4; npc = 32'd0; instr = 32'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (pc !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc: got %h exp %h", pc, 32'h0000_3000); end
    n_chk++; if (ifid_pc4 !== 32'd0) begin n_fail++; $display("FAIL reset_pc4: got %h exp %h", ifid_pc4, 32'd0); end
    n_chk++; if (ifid_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr: got %h exp %h", ifid_instr, 32'd0); end
    n_chk++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", ifid_valid); end
    n_chk++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", stall_err); end
`ifdef IFID_PERF_CNT_EN
    n_chk++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_perf: got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
`endif
  endtask

  task automatic test_run();
    do_reset();
    instr = 32'h2008_0005;
    tick();
    n_chk++; if (pc !== 32'h0000_3004) begin n_fail++; $display("FAIL boot_pc: got %h exp %h", pc, 32'h0000_3004); end
    n_chk++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h2008_0005) begin n_fail++; $display("FAIL boot_ifid: got %b/%h exp 1/%h", ifid_valid, ifid_instr, 32'h2008_0005); end
    n_chk++; if (ifid_pc4 !== 32'h0000_3004) begin n_fail++; $display("FAIL boot_pc4: got %h exp %h", ifid_pc4, 32'h0000_3004); end
    tick();
    n_chk++; if (pc !== 32'h0000_3008) begin n_fail++; $display("FAIL run_pc2: got %h exp %h", pc, 32'h0000_3008); end
    tick();
    n_chk++; if (pc !== 32'h0000_300C) begin n_fail++; $display("FAIL run_pc3: got %h exp %h", pc, 32'h0000_300C); end
    n_chk++; if (ifid_pc4 !== 32'h0000_300C || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL run_pc4_3: got %h/%b exp %h/1", ifid_pc4, ifid_valid, 32'h0000_300C); end
  endtask

  task automatic test_stall_flush();
    do_reset();
    instr = 32'h2008_0005;
    tick();
    instr = 32'h2008_0006;
    tick();
    n_chk++; if (pc !== 32'h0000_3008 || ifid_instr !== 32'h2008_0006) begin n_fail++; $display("FAIL pre_stall: got %h/%h exp %h/%h", pc, ifid_instr, 32'h0000_3008, 32'h2008_0006); end
    ifid_wr = 1'b0; iflush = 1'b1; npc = 32'h0000_3040; npc_op = NPC_BRANCH; instr = 32'h2008_0007;
    tick();
    n_chk++; if (pc !== 32'h0000_3008 || ifid_instr !== 32'h2008_0006) begin n_fail++; $display("FAIL stall1_hold: got %h/%h exp %h/%h", pc, ifid_instr, 32'h0000_3008, 32'h2008_0006); end
    tick();
    n_chk++; if (pc !== 32'h0000_3008 || ifid_pc4 !== 32'h0000_3008 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL stall2_hold: got %h/%h/%b exp %h/%h/1", pc, ifid_pc4, ifid_valid, 32'h0000_3008, 32'h0000_3008); end
    n_chk++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL stall2_err: got %b exp 0", stall_err); end
    ifid_wr = 1'b1; iflush = 1'b0; npc_op = NPC_PLUS4;
    tick();
    n_chk++; if (pc !== 32'h0000_300C || ifid_instr !== 32'h2008_0007 || ifid_pc4 !== 32'h0000_300C) begin n_fail++; $display("FAIL stall_exit: got %h/%h/%h exp %h/%h/%h", pc, ifid_instr, ifid_pc4, 32'h0000_300C, 32'h2008_0007, 32'h0000_300C); end
    iflush = 1'b1; npc = 32'h0000_3040; npc_op = NPC_JUMP; instr = 32'h2008_0008;
    tick();
    n_chk++; if (pc !== 32'h0000_3040) begin n_fail++; $display("FAIL flush_pc: got %h exp %h", pc, 32'h0000_3040); end
    n_chk++; if (ifid_instr !== 32'd0 || ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0000_3010) begin n_fail++; $display("FAIL flush_bubble: got %h/%b/%h exp 0/0/%h", ifid_instr, ifid_valid, ifid_pc4, 32'h0000_3010); end
    iflush = 1'b0; npc_op = NPC_PLUS4; instr = 32'h2008_0009;
    tick();
    n_chk++; if (pc !== 32'h0000_3044 || ifid_instr !== 32'h2008_0009 || ifid_valid !== 1'b1 || ifid_pc4 !== 32'h0000_3044) begin n_fail++; $display("FAIL post_flush: got %h/%h/%b/%h exp %h/%h/1/%h", pc, ifid_instr, ifid_valid, ifid_pc4, 32'h0000_3044, 32'h2008_0009, 32'h0000_3044); end
`ifdef IFID_PERF_CNT_EN
    n_chk++; if (stall_cnt !== 32'd2) begin n_fail++; $display("FAIL perf_stall: got %0d exp 2", stall_cnt); end
    n_chk++; if (flush_cnt !== 32'd1) begin n_fail++; $display("FAIL perf_flush: got %0d exp 1", flush_cnt); end
`endif
  endtask

  task automatic test_stall_to_flush();
    do_reset();
    instr = 32'h1111_0000;
    tick();
    ifid_wr = 1'b0; iflush = 1'b1; npc_op = NPC_BRANCH; npc = 32'h0000_5000;
    tick();
    n_chk++; if (pc !== 32'h0000_3004) begin n_fail++; $display("FAIL branch_stall_hold: got %h exp %h", pc, 32'h0000_3004); end
    ifid_wr = 1'b1; npc = 32'h0000_3043;
    tick();
    n_chk++; if (pc !== 32'h0000_3040 || ifid_valid !== 1'b0 || ifid_pc4 !== 32'h0000_3008) begin n_fail++; $display("FAIL stall_exit_flush: got %h/%b/%h exp %h/0/%h", pc, ifid_valid, ifid_pc4, 32'h0000_3040, 32'h0000_3008); end
  endtask

  task automatic test_stall_err();
    do_reset();
    instr = 32'h2222_0000;
    tick();
    ifid_wr = 1'b0;
    repeat (14) tick();
    n_chk++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL err_at14: got %b exp 0", stall_err); end
    ifid_wr = 1'b1;
    tick();
    ifid_wr = 1'b0;
    repeat (14) tick();
    n_chk++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL err_cleared_run: got %b exp 0", stall_err); end
    tick();
    n_chk++; if (stall_err !== 1'b1) begin n_fail++; $display("FAIL err_at15: got %b exp 1", stall_err); end
    tick();
    n_chk++; if (stall_err !== 1'b1) begin n_fail++; $display("FAIL err_at16: got %b exp 1", stall_err); end
    ifid_wr = 1'b1;
    tick();
    n_chk++; if (stall_err !== 1'b1 || pc !== 32'h0000_300C) begin n_fail++; $display("FAIL err_sticky: got %b/%h exp 1/%h", stall_err, pc, 32'h0000_300C); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (stall_err !== 1'b0) begin n_fail++; $display("FAIL err_rst: got %b exp 0", stall_err); end
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    instr = 32'h3333_0000;
    tick();
    iflush = 1'b1; npc = 32'hFFFF_FFFF; npc_op = NPC_JR;
    tick();
    n_chk++; if (pc !== 32'hFFFF_FFFC || ifid_pc4 !== 32'h0000_3008) begin n_fail++; $display("FAIL wrap_redirect: got %h/%h exp %h/%h", pc, ifid_pc4, 32'hFFFF_FFFC, 32'h0000_3008); end
    iflush = 1'b0; npc_op = NPC_PLUS4; instr = 32'h3333_0001;
    tick();
    n_chk++; if (pc !== 32'd0 || ifid_pc4 !== 32'd0 || ifid_instr !== 32'h3333_0001) begin n_fail++; $display("FAIL wrap_pc: got %h/%h/%h exp 0/0/%h", pc, ifid_pc4, ifid_instr, 32'h3333_0001); end
  endtask

  task automatic test_async_reset();
    do_reset();
    instr = 32'h4444_0000;
    tick();
    iflush = 1'b1; npc = 32'h0000_3080;
    tick();
    n_chk++; if (pc !== 32'h0000_3080) begin n_fail++; $display("FAIL async_pre: got %h exp %h", pc, 32'h0000_3080); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (pc !== 32'h0000_3000 || ifid_pc4 !== 32'd0 || ifid_instr !== 32'd0 || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst: got %h/%h/%h/%b exp %h/0/0/0", pc, ifid_pc4, ifid_instr, ifid_valid, 32'h0000_3000); end
    tick();
    #2 rst = 1'b0; iflush = 1'b0; instr = 32'h4444_0001;
    tick();
    n_chk++; if (pc !== 32'h0000_3004 || ifid_instr !== 32'h4444_0001 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL async_reboot: got %h/%h/%b exp %h/%h/1", pc, ifid_instr, ifid_valid, 32'h0000_3004, 32'h4444_0001); end
  endtask

  initial begin
    rst = 1'b1; ifid_wr = 1'b1; iflush = 1'b0; npc_op = NPC_PLUS4; npc = 32'd0; instr = 32'd0;
    test_reset();
    test_run();
    test_stall_flush();
    test_stall_to_flush();
    test_stall_err();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
